// File: rtl/scic_pkg.sv
// Shared SCIC definitions: I/O register offsets, memory FSM states and CPU opcodes.
// Imported by the memory responder, the CPU and the benches.
package scic_pkg;

    localparam int IO_GPIO_OUT = 0;
    localparam int IO_GPIO_IN  = 1;
    localparam int IO_CYCLES   = 2;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // CPU instruction words carry the opcode in the top nibble.
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'h8;

    function automatic logic [31:0] make_insn(input logic [3:0] op, input logic [27:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/scic_ram.sv
// Word RAM for the SCIC memory: one synchronous write port, one combinational read port.
// Contents are never reset so a loaded image survives a CPU reset.
module scic_ram #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [1 << DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/scic_memory.sv
// SCIC memory-side responder: boot loader FSM, word RAM, GPIO registers and cycle counter.
// Reads are combinational from address; all writes land on the rising clock edge.
module scic_memory
    import scic_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        cpu_reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_done,
    output logic        load_ready,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST   = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [15:0]           A_GPIO_OUT = IO_BASE + 16'(IO_GPIO_OUT);
    localparam logic [15:0]           A_GPIO_IN  = IO_BASE + 16'(IO_GPIO_IN);
    localparam logic [15:0]           A_CYCLES   = IO_BASE + 16'(IO_CYCLES);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [31:0]           gpio_out_q, gpio_out_d;
    logic [31:0]           cycles_q, cycles_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  load_ready_q, load_ready_d;

    logic                  sel_ram, sel_gpio_out, sel_gpio_in, sel_cycles;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    // Decode is exact: nothing above the RAM aliases back into it.
    assign sel_ram      = ({16'd0, address} < 32'(DEPTH));
    assign sel_gpio_out = (address == A_GPIO_OUT);
    assign sel_gpio_in  = (address == A_GPIO_IN);
    assign sel_cycles   = (address == A_CYCLES);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gpio_out_d = gpio_out_q;
        cycles_d   = cycles_q;
        ram_we     = 1'b0;
        ram_waddr  = address[DEPTH_LOG2-1:0];
        ram_wdata  = data_in;
        case (state_q)
            ST_LOAD: begin
                cycles_d = 32'd0;
                if (load_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q;
                    ram_wdata = load_data;
                    ptr_d     = ptr_q + 1'b1;
                    if (load_done || ptr_q == PTR_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cycles_d = cycles_q + 32'd1;
                if (we) begin
                    ram_we = sel_ram;
                    if (sel_gpio_out) gpio_out_d = data_in;
                    if (sel_cycles)   cycles_d   = 32'd0;
                end
            end
            default: ;
        endcase
        // A reset edge commits nothing, including a pending RAM write.
        if (reset) begin
            ram_we = 1'b0;
        end
        cpu_reset_d  = (state_d == ST_LOAD);
        load_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            gpio_out_q   <= 32'd0;
            cycles_q     <= 32'd0;
            cpu_reset_q  <= 1'b1;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gpio_out_q   <= gpio_out_d;
            cycles_q     <= cycles_d;
            cpu_reset_q  <= cpu_reset_d;
            load_ready_q <= load_ready_d;
        end
    end

    scic_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(address[DEPTH_LOG2-1:0]),
        .rdata(ram_rdata)
    );

    always_comb begin
        data_out = 32'd0;
        if (sel_ram)           data_out = ram_rdata;
        else if (sel_gpio_out) data_out = gpio_out_q;
        else if (sel_gpio_in)  data_out = gpio_in;
        else if (sel_cycles)   data_out = cycles_q;
    end

    assign cpu_reset  = cpu_reset_q;
    assign load_ready = load_ready_q;
    assign gpio_out   = gpio_out_q;

endmodule
